// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32 ALU instructions and feeds operands to EX through a 2-entry skid buffer.
// Optional macro ALU_ISSUE_MUL_EN enables decode of the R-type MUL encoding.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [2:0]      alu_ctrl_o,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [RD_W-1:0] rd_addr_o,
    output logic            reg_write_o,
    output logic            illegal_o
);
    // state | meaning
    // EMPTY | no entry held, outputs invalid
    // ONE   | HEAD valid, SKID free
    // TWO   | HEAD and SKID valid, upstream stalled
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

    typedef struct packed {
        logic [2:0]      ctrl;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [RD_W-1:0] rd;
        logic            rw;
        logic            ill;
    } entry_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SRAI = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;
`ifdef ALU_ISSUE_MUL_EN
    localparam logic [2:0] ALU_MUL  = 3'b011;
`endif

    localparam entry_t ENTRY_RST = '{ctrl: ALU_ADD, d1: '0, d2: '0, rd: '0, rw: 1'b0, ill: 1'b0};

    state_t state_q, state_d;
    entry_t head_q, skid_q, dec;
    logic   acc, pop;
    logic   load_head_in, load_skid, head_from_skid;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_sext;
    logic [4:0]      unused_rs1_idx;

    assign opcode         = instr_i[6:0];
    assign funct3         = instr_i[14:12];
    assign funct7         = instr_i[31:25];
    assign imm_sext       = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign unused_rs1_idx = instr_i[19:15];

    always_comb begin
        dec      = '{ctrl: ALU_ADD, d1: rs1_data_i, d2: rs2_data_i,
                     rd: RD_W'(instr_i[11:7]), rw: 1'b0, ill: 1'b1};
        if (opcode == 7'b0110011) begin
            dec.ill = 1'b0;
            unique case ({funct7, funct3})
                {7'b0000000, 3'b111}: dec.ctrl = ALU_AND;
                {7'b0000000, 3'b100}: dec.ctrl = ALU_XOR;
                {7'b0000000, 3'b001}: dec.ctrl = ALU_SLL;
                {7'b0000000, 3'b000}: dec.ctrl = ALU_ADD;
                {7'b0100000, 3'b000}: dec.ctrl = ALU_SUB;
`ifdef ALU_ISSUE_MUL_EN
                {7'b0000001, 3'b000}: dec.ctrl = ALU_MUL;
`endif
                default:              dec.ill  = 1'b1;
            endcase
        end else if (opcode == 7'b0010011) begin
            if (funct3 == 3'b000) begin
                dec.ill = 1'b0;
                dec.d2  = imm_sext;
            end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
                dec.ill  = 1'b0;
                dec.ctrl = ALU_SRAI;
                dec.d2   = imm_sext;
            end
        end
        dec.rw = ~dec.ill;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    assign acc = in_valid_i & in_ready_o;
    assign pop = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: if (acc)          state_d = S_ONE;
                S_ONE:   if (acc && !pop)  state_d = S_TWO;
                         else if (!acc && pop) state_d = S_EMPTY;
                S_TWO:   if (pop)          state_d = S_ONE;
                default:                   state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready_o     = (state_q != S_TWO);
        out_valid_o    = (state_q != S_EMPTY);
        load_head_in   = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        if (!flush_i) begin
            unique case (state_q)
                S_EMPTY: load_head_in   = acc;
                S_ONE: begin
                    load_head_in = acc & pop;
                    load_skid    = acc & ~pop;
                end
                S_TWO:   head_from_skid = pop;
                default: ;
            endcase
        end
    end

    // Payload only moves on a load; out_valid_o qualifies whatever is left behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= ENTRY_RST;
            skid_q <= ENTRY_RST;
        end else begin
            if (load_head_in)        head_q <= dec;
            else if (head_from_skid) head_q <= skid_q;
            if (load_skid)           skid_q <= dec;
        end
    end

    assign alu_ctrl_o  = head_q.ctrl;
    assign data1_o     = head_q.d1;
    assign data2_o     = head_q.d2;
    assign rd_addr_o   = head_q.rd;
    assign reg_write_o = head_q.rw;
    assign illegal_o   = head_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed literal cases followed by randomized
// valid/ready/flush/reset traffic compared against a queue-based reference model.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, rs1, rs2, data1, data2;
    logic [2:0]  alu_ctrl;
    logic [4:0]  rd_addr;
    logic        reg_write, illegal;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } ent_t;

    ent_t q[$];
    bit   m_acc, m_pop;

    alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .alu_ctrl_o(alu_ctrl), .data1_o(data1), .data2_o(data2),
        .rd_addr_o(rd_addr), .reg_write_o(reg_write), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: table of legal ALU encodings, everything else is illegal ADD with rs2.
    function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        ent_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int   imm;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        imm = int'($signed(ins[31:20]));
        e = '{ctrl: 3'd2, d1: a, d2: b, rd: ins[11:7], rw: 1'b0, ill: 1'b1};
        if (op == 7'h33) begin
            if      (f7 == 7'h00 && f3 == 3'd7) e.ctrl = 3'd0;
            else if (f7 == 7'h00 && f3 == 3'd4) e.ctrl = 3'd1;
            else if (f7 == 7'h00 && f3 == 3'd1) e.ctrl = 3'd7;
            else if (f7 == 7'h00 && f3 == 3'd0) e.ctrl = 3'd2;
            else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 3'd6;
`ifdef ALU_ISSUE_MUL_EN
            else if (f7 == 7'h01 && f3 == 3'd0) e.ctrl = 3'd3;
`endif
            else return e;
            e.ill = 1'b0; e.rw = 1'b1;
        end else if (op == 7'h13 && (f3 == 3'd0 || (f3 == 3'd5 && f7 == 7'h20))) begin
            e.ctrl = (f3 == 3'd0) ? 3'd2 : 3'd4;
            e.d2   = 32'(imm);
            e.ill  = 1'b0; e.rw = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, r1, r2;
        logic [11:0] imm;
        rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0: return {7'h00, r2, r1, 3'd7, rd, 7'h33};
            1: return {7'h00, r2, r1, 3'd4, rd, 7'h33};
            2: return {7'h00, r2, r1, 3'd1, rd, 7'h33};
            3: return {7'h00, r2, r1, 3'd0, rd, 7'h33};
            4: return {7'h20, r2, r1, 3'd0, rd, 7'h33};
            5: return {7'h01, r2, r1, 3'd0, rd, 7'h33};
            6: return {imm, r1, 3'd0, rd, 7'h13};
            7: return {7'h20, r2, r1, 3'd5, rd, 7'h13};
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) begin
        m_acc = in_valid && (q.size() < 2);
        m_pop = (q.size() > 0) && out_ready;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back(model_decode(instr, rs1, rs2));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("ctrl", 32'(alu_ctrl), 32'(q[0].ctrl));
                chk("data1", data1, q[0].d1);
                chk("data2", data2, q[0].d2);
                chk("rd", 32'(rd_addr), 32'(q[0].rd));
                chk("reg_write", 32'(reg_write), 32'(q[0].rw));
                chk("illegal", 32'(illegal), 32'(q[0].ill));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd2);
        chk("rst_data1", data1, 32'd0);
        chk("rst_data2", data2, 32'd0);
        chk("rst_rd", 32'(rd_addr), 32'd0);
        chk("rst_rw", 32'(reg_write), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);

        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        instr = 32'h002081B3; rs1 = 32'd5; rs2 = 32'd7;
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_ctrl", 32'(alu_ctrl), 32'd2);
        chk("add_d1", data1, 32'd5);
        chk("add_d2", data2, 32'd7);
        chk("add_rd", 32'(rd_addr), 32'd3);
        chk("add_rw", 32'(reg_write), 32'd1);
        instr = 32'h402081B3; rs1 = 32'd10; rs2 = 32'd3;
        @(negedge clk);
        chk("sub_ctrl", 32'(alu_ctrl), 32'd6);
        instr = 32'hFFF00293;
        @(negedge clk);
        chk("addi_ctrl", 32'(alu_ctrl), 32'd2);
        chk("addi_d2", data2, 32'hFFFFFFFF);
        chk("addi_rd", 32'(rd_addr), 32'd5);
        instr = 32'h4032D313;
        @(negedge clk);
        chk("srai_ctrl", 32'(alu_ctrl), 32'd4);
        chk("srai_d2", data2, 32'h00000403);
        chk("srai_rd", 32'(rd_addr), 32'd6);
        instr = 32'h0000007F;
        @(negedge clk);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_ctrl", 32'(alu_ctrl), 32'd2);
        chk("ill_rw", 32'(reg_write), 32'd0);
        in_valid = 1'b0;

        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; rs1 = 32'd1; rs2 = 32'd2;
        @(negedge clk);
        instr = 32'h0020C233;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head_a", 32'(rd_addr), 32'd3);
        @(negedge clk);
        chk("bp_hold_a", 32'(rd_addr), 32'd3);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", 32'(rd_addr), 32'd4);
        chk("bp_ctrl_b", 32'(alu_ctrl), 32'd1);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
        @(negedge clk);
        instr = 32'h0020C233;
        @(negedge clk);
        flush = 1'b1; instr = 32'h402081B3;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl2_valid", 32'(out_valid), 32'd0);
        chk("fl2_ready", 32'(in_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("fl2_gone", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
        @(negedge clk);
        flush = 1'b1; instr = 32'h402081B3;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("fl1_gone", 32'(out_valid), 32'd0);

        in_valid = 1'b1; instr = 32'h022081B3;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef ALU_ISSUE_MUL_EN
        chk("mul_ctrl", 32'(alu_ctrl), 32'd3);
        chk("mul_ill", 32'(illegal), 32'd0);
        chk("mul_rw", 32'(reg_write), 32'd1);
`else
        chk("mul_ctrl", 32'(alu_ctrl), 32'd2);
        chk("mul_ill", 32'(illegal), 32'd1);
        chk("mul_rw", 32'(reg_write), 32'd0);
`endif

        repeat (4000) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            instr     = rand_instr();
            rs1       = $urandom;
            rs2       = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
